// File: rtl/fp_sp_to_u32_pipe.sv
// FloPoCo single-precision float to unsigned 32-bit integer, with saturation, status flags
// and an elastic valid/ready pipeline of NUM_STAGES registers gated by a global clock enable.
// Optional macro FP_SP_TO_U32_ROUND_NEAREST_EN selects round-to-nearest-even instead of truncation.
module fp_sp_to_u32_pipe #(
  parameter int NUM_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [33:0] I,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] O,
  output logic [2:0]  flags
);

  logic [1:0]  w_exn;
  logic        w_sign;
  logic [7:0]  w_exp;
  logic [23:0] w_mant;
  logic [4:0]  w_shamt;
  logic [54:0] w_big;
  logic [31:0] w_res;
  logic [2:0]  w_flg;
`ifdef FP_SP_TO_U32_ROUND_NEAREST_EN
  logic [32:0] w_rnd;
`endif

  assign w_exn   = I[33:32];
  assign w_sign  = I[31];
  assign w_exp   = I[30:23];
  assign w_mant  = {1'b1, I[22:0]};
  // (exp - 127) mod 32 == exp[4:0] + 1; only used when 0 <= e <= 31
  assign w_shamt = w_exp[4:0] + 5'd1;
  // Integer part lands in [54:23], discarded fraction in [22:0]
  assign w_big   = {31'b0, w_mant} << w_shamt;

  always_comb begin
    w_res = '0;
    w_flg = '0;
`ifdef FP_SP_TO_U32_ROUND_NEAREST_EN
    w_rnd = '0;
`endif
    case (w_exn)
      2'b00: begin
      end
      2'b11: w_flg = 3'b100;
      2'b10: begin
        if (w_sign) begin
          w_flg = 3'b100;
        end else begin
          w_res = '1;
          w_flg = 3'b010;
        end
      end
      default: begin
        if (w_exp < 8'd127) begin
`ifdef FP_SP_TO_U32_ROUND_NEAREST_EN
          // 0.5 <= |x| < 1: the hidden 1 is the guard bit, fraction is sticky
          if (w_exp == 8'd126 && (|I[22:0])) begin
            if (w_sign) begin
              w_flg = 3'b100;
            end else begin
              w_res = 32'd1;
              w_flg = 3'b001;
            end
          end else begin
            w_flg = 3'b001;
          end
`else
          w_flg = 3'b001;
`endif
        end else if (w_sign) begin
          w_flg = 3'b100;
        end else if (w_exp >= 8'd159) begin
          w_res = '1;
          w_flg = 3'b010;
        end else begin
`ifdef FP_SP_TO_U32_ROUND_NEAREST_EN
          w_rnd = {1'b0, w_big[54:23]}
                + {32'b0, w_big[22] & ((|w_big[21:0]) | w_big[23])};
          if (w_rnd[32]) begin
            w_res = '1;
            w_flg = 3'b010;
          end else begin
            w_res = w_rnd[31:0];
            w_flg = {2'b00, |w_big[22:0]};
          end
`else
          w_res = w_big[54:23];
          w_flg = {2'b00, |w_big[22:0]};
`endif
        end
      end
    endcase
  end

  generate
    if (NUM_STAGES < 0 || NUM_STAGES > 4) begin : g_bad_stages
      $error("fp_sp_to_u32_pipe: NUM_STAGES must be in 0..4");
    end

    if (NUM_STAGES == 0) begin : g_comb
      assign in_ready  = out_ready & ce;
      assign out_valid = in_valid;
      assign O         = w_res;
      assign flags     = w_flg;
    end else begin : g_pipe
      logic                  w_adv;
      logic [NUM_STAGES-1:0] r_vld;
      logic [31:0]           r_o [NUM_STAGES];
      logic [2:0]            r_f [NUM_STAGES];

      // Only the output stage is backpressured; bubbles are overwritten as the pipe shifts
      assign w_adv = ce & (~r_vld[NUM_STAGES-1] | out_ready);

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_vld <= '0;
          for (int unsigned k = 0; k < NUM_STAGES; k++) begin
            r_o[k] <= '0;
            r_f[k] <= '0;
          end
        end else if (w_adv) begin
          r_vld[0] <= in_valid;
          r_o[0]   <= w_res;
          r_f[0]   <= w_flg;
          for (int unsigned k = 1; k < NUM_STAGES; k++) begin
            r_vld[k] <= r_vld[k-1];
            r_o[k]   <= r_o[k-1];
            r_f[k]   <= r_f[k-1];
          end
        end
      end

      assign in_ready  = w_adv;
      assign out_valid = r_vld[NUM_STAGES-1];
      assign O         = r_o[NUM_STAGES-1];
      assign flags     = r_f[NUM_STAGES-1];
    end
  endgenerate

endmodule

// File: tb/tb_fp_sp_to_u32_pipe.sv
// Scoreboard bench for fp_sp_to_u32_pipe: directed test-plan words, a backpressure/ce stream,
// a mid-stream reset and randomized traffic, all checked against an arithmetic reference model.
module tb_fp_sp_to_u32_pipe;

  localparam int NS = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic        in_valid;
  logic        in_ready;
  logic [33:0] I;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] O;
  logic [2:0]  flags;

  fp_sp_to_u32_pipe #(.NUM_STAGES(NS)) dut (
    .clk(clk), .rst(rst), .ce(ce),
    .in_valid(in_valid), .in_ready(in_ready), .I(I),
    .out_valid(out_valid), .out_ready(out_ready), .O(O), .flags(flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [33:0] x;
    logic [31:0] o;
    logic [2:0]  f;
    int unsigned stamp;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  int unsigned adv_cnt  = 0;
  bit          rand_ctl = 1'b0;

  // Reference: value = {1,frac} * 2^(e-23), reduced with wide integer arithmetic
  function automatic void model(input logic [33:0] x, output logic [31:0] o,
                                output logic [2:0] f);
    int e, sh;
    longint unsigned mant, q, r, half;
    o = '0;
    f = '0;
    e = int'(x[30:23]) - 127;
    mant = 64'h80_0000 | 64'(x[22:0]);
    case (x[33:32])
      2'b00: ;
      2'b11: f = 3'b100;
      2'b10: if (x[31]) f = 3'b100; else begin o = '1; f = 3'b010; end
      default: begin
        if (x[31] && e >= 0) f = 3'b100;
        else if (e >= 32) begin o = '1; f = 3'b010; end
        else if (e >= 23) o = 32'(mant << (e - 23));
        else begin
          sh = 23 - e;
          if (sh > 40) begin
            q = 0; r = mant; half = 64'd1 << 40;
          end else begin
            q = mant >> sh; r = mant - (q << sh); half = 64'd1 << (sh - 1);
          end
`ifdef FP_SP_TO_U32_ROUND_NEAREST_EN
          if (r > half || (r == half && q[0])) q = q + 1;
`endif
          if (x[31]) f = (q == 0) ? 3'b001 : 3'b100;
          else if (q >= 64'h1_0000_0000) begin o = '1; f = 3'b010; end
          else begin o = q[31:0]; f = {2'b00, r != 0}; end
        end
      end
    endcase
  endfunction

  function automatic logic [33:0] rand_word();
    logic [1:0]  exn;
    logic [7:0]  ex;
    logic [22:0] fr;
    int unsigned k;
    k   = $urandom_range(0, 15);
    exn = (k == 0) ? 2'b00 : (k == 1) ? 2'b10 : (k == 2) ? 2'b11 : 2'b01;
    ex  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(100, 165));
    fr  = 23'($urandom);
    if ($urandom_range(0, 3) == 0) fr[15:0] = '0;
    return {exn, 1'($urandom), ex, fr};
  endfunction

  // Acceptance side: record expectation and count advancing cycles
  always @(negedge clk) begin
    exp_t ent;
    if (rst) begin
      if (in_valid && in_ready) begin
        ent.x = I;
        model(I, ent.o, ent.f);
        ent.stamp = adv_cnt;
        sb.push_back(ent);
      end
      if (in_ready) adv_cnt++;
    end
  end

  // Output side: handshake rule, ordering, value, flags and latency
  always @(negedge clk) begin
    exp_t        m;
    logic        exp_rdy;
    int unsigned lat;
    #1;
    if (rst) begin
      exp_rdy = (NS == 0) ? (ce && out_ready) : (ce && (!out_valid || out_ready));
      checks++;
      if (in_ready !== exp_rdy) begin
        failures++;
        $display("FAIL in_ready: got %b want %b (ce=%b out_valid=%b out_ready=%b) t=%0t",
                 in_ready, exp_rdy, ce, out_valid, out_ready, $time);
      end
      if (out_valid && out_ready && ce) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output: got O=%h flags=%b want no output t=%0t",
                   O, flags, $time);
        end else begin
          m = sb.pop_front();
          lat = adv_cnt - 1 - m.stamp;
          if (O !== m.o || flags !== m.f || lat != NS) begin
            failures++;
            $display("FAIL result I=%h: got O=%h flags=%b lat=%0d want O=%h flags=%b lat=%0d",
                     m.x, O, flags, lat, m.o, m.f, NS);
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ctl) begin
      out_ready = ($urandom_range(0, 3) != 0);
      ce        = ($urandom_range(0, 7) != 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h t=%0t", name, got, want, $time);
    end
  endtask

  task automatic send(input logic [33:0] x);
    int unsigned n;
    bit got;
    I = x;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      got = in_ready;
      n++;
      @(posedge clk);
      #1;
    end while (!got && n < 300);
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: I=%h not accepted within %0d cycles", x, n);
    end
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (sb.size() != 0 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: got %0d words pending want 0", sb.size());
      sb.delete();
    end
  endtask

  logic [33:0] plan [10] = '{
    34'h13F800000, 34'h140700000, 34'h14F7FFFFF, 34'h14F800000, 34'h1C0000000,
    34'h300000000, 34'h080000000, 34'h200000000, 34'h140200000, 34'h140600000
  };

  initial begin
    rst = 1'b0; ce = 1'b1; out_ready = 1'b1; in_valid = 1'b0; I = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_O", O, 32'd0);
    chk("reset_flags", 32'(flags), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Isolated test-plan words (latency checked per word), then back-to-back
    foreach (plan[i]) begin
      send(plan[i]);
      in_valid = 1'b0;
      drain();
    end
    foreach (plan[i]) send(plan[i]);
    in_valid = 1'b0;
    drain();

    // 16-word stream with output stall and clock-enable freeze
    fork
      begin
        for (int i = 0; i < 16; i++) send(rand_word());
        in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 ce = 1'b0;
        repeat (3) @(posedge clk);
        #1 ce = 1'b1;
      end
    join
    drain();

    // Reset with two words in flight
    send(34'h140700000);
    send(34'h14F7FFFFF);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("midreset_out_valid", 32'(out_valid), 32'd0);
    chk("midreset_O", O, 32'd0);
    chk("midreset_flags", 32'(flags), 32'd0);
    sb.delete();
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    send(34'h13F800000);
    in_valid = 1'b0;
    drain();

    // Randomized traffic with random backpressure and clock enable
    rand_ctl = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      send(rand_word());
    end
    in_valid = 1'b0;
    drain();
    rand_ctl = 1'b0;
    ce = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_sp_to_u32_pipe.md
Name: fp_sp_to_u32_pipe

Overview:
- Converts a FloPoCo single-precision float (34-bit: 2-bit exception, sign, 8-bit exponent, 23-bit fraction) to an unsigned 32-bit integer.
- Saturates out-of-range values and reports status flags.
- Inverse companion of the U32-to-FP_sp converters; sits on the datapath return path where float results feed integer consumers.
- Elastic valid/ready pipeline with a configurable number of stages, plus a global clock enable.

Parameters:
NUM_STAGES, 2, register stages between input and output; legal range 0..4; any other value is an elaboration error.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
ce  in  1  clock enable; low freezes the entire pipeline
in_valid  in  1  input word valid
in_ready  out  1  input accepted when in_valid && in_ready
I  in  34  FloPoCo float: [33:32] exn (00 zero, 01 normal, 10 inf, 11 NaN), [31] sign, [30:23] exp (bias 127), [22:0] fraction
out_valid  out  1  result valid
out_ready  in  1  downstream accepts when out_valid && out_ready
O  out  32  unsigned integer result
flags  out  3  [2] invalid, [1] overflow, [0] inexact

Behaviour:
- Reset (rst=0, asynchronous): all stage valid bits, O and flags clear to 0 immediately. out_valid=0.
- Advance rule: advance = ce && (!out_valid || out_ready). in_ready = advance. All stages shift together on advance and hold otherwise.
- Bubbles travel through the pipe; only the output stage is backpressured. No word is dropped or duplicated, and order is preserved.
- Latency is NUM_STAGES advancing cycles from acceptance to out_valid.
- NUM_STAGES=0 is purely combinational: out_valid=in_valid, in_ready=out_ready && ce, and O/flags follow I.
- Arithmetic (default, truncate toward zero). Let e = exp-127 and m = {1,fraction} (24 bits):
  - exn=00 (±0): O=0, flags=000.
  - exn=11 (NaN): O=0, invalid.
  - exn=10, sign=0: O=FFFFFFFF, overflow.
  - exn=10, sign=1: O=0, invalid.
  - Normal, e<0: O=0, inexact (sign is irrelevant).
  - Normal, sign=1, e>=0: O=0, invalid.
  - Normal, sign=0, e>=32: O=FFFFFFFF, overflow.
  - Normal, sign=0, 23<=e<=31: O=m<<(e-23), exact.
  - Normal, sign=0, 0<=e<23: O=m>>(23-e); inexact set if any shifted-out bit is 1.
  - Flags are mutually exclusive, with priority invalid > overflow > inexact.
- Stage split (recommended, not mandated): S1 decodes exn/sign/e and classifies; S2 runs the barrel shift plus sticky; S3/S4 are optional retiming registers. Stage contents are not observable; only latency and handshake are.
- ce low while out_valid=1 and out_ready=1: the output holds and no transfer completes, because advance is 0. The downstream must treat a transfer as occurring only when advance is high; this is documented for integrators.
- Reset asserted mid-stream discards all in-flight words.

Optional Feature:
- Macro: FP_SP_TO_U32_ROUND_NEAREST_EN.
- When defined:
  - Results round to nearest, ties to even, using guard bit and sticky for 0<=e<23.
  - For e=-1 (0.5<=|x|<1), round using the leading 1 as the guard bit.
  - A negative value that rounds to 0 gives O=0 with inexact only; a negative value that rounds to nonzero is invalid.
  - Rounding carry to 2^32 gives O=FFFFFFFF with overflow.
  - Latency is unchanged.
- When undefined: truncation as specified above, and the rounding logic is absent.

Test Plan:
- 1.0 (I=34'h13F800000) -> O=00000001, flags=000, out_valid exactly NUM_STAGES advancing cycles after acceptance.
- 3.75 (34'h140700000) -> O=3, inexact. 4294967040.0 (34'h14F7FFFFF) -> O=FFFFFF00, flags=000. 2^32 (34'h14F800000) -> O=FFFFFFFF, overflow.
- -2.0 (34'h1C0000000) -> O=0, invalid. NaN (34'h300000000) -> O=0, invalid. -0 (34'h080000000) -> O=0, flags=000. +inf (34'h200000000) -> O=FFFFFFFF, overflow.
- Back-to-back stream of 16 words with out_ready low for 5 cycles mid-stream, and ce low for 3 cycles -> all 16 results emerge in order with no loss or duplication. in_ready=0 whenever out_valid && !out_ready or ce=0.
- rst pulsed low while 2 words are in flight -> out_valid=0 immediately (asynchronous). Next accepted word emerges after NUM_STAGES cycles with a correct value.
- With FP_SP_TO_U32_ROUND_NEAREST_EN: 2.5 (34'h140200000) -> 2; 3.5 (34'h140600000) -> 4; 0.5 -> 0; -0.4 -> 0 inexact; -0.6 -> invalid; 4294967295.5 (34'h14F800000, which is 2^32 after float rounding) -> FFFFFFFF overflow. Without the macro: 2.5->2 and 3.5->3, both inexact.
